// File: rtl/vga_sync.sv
// 640x480 @ 60 Hz VGA timing generator: pixel-enable divider, h/v counters,
// active-low syncs aligned with the pixel coordinates, and a frame-start pulse.
module vga_sync #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DW-1:0] div_cnt;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic [9:0]    h_next;
    logic [9:0]    v_next;
    logic          rst_q;
    logic          frame_wrap;

    always_comb begin
        h_next     = h_cnt;
        v_next     = v_cnt;
        frame_wrap = 1'b0;
        if (p_tick) begin
            if (h_cnt == H_LAST) begin
                h_next = 10'd0;
                if (v_cnt == V_LAST) begin
                    v_next     = 10'd0;
                    frame_wrap = 1'b1;
                end else begin
                    v_next = v_cnt + 10'd1;
                end
            end else begin
                h_next = h_cnt + 10'd1;
            end
        end
    end

    // Syncs are computed from the next counter values so they change on the
    // same edge as pixel_x/pixel_y.
    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            div_cnt     <= '0;
            p_tick      <= 1'b0;
            h_cnt       <= 10'd0;
            v_cnt       <= 10'd0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            p_tick      <= (div_cnt == DIV_LAST);
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            hsync       <= !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
            vsync       <= !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
            frame_start <= frame_wrap;
        end
    end

    assign pixel_x = h_cnt;
    assign pixel_y = v_cnt;

    // rst_q keeps the renderer dark through reset and the clk after release.
    assign video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS) && !rst_q;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: full-size instance for line-level timing, a shrunken
// instance for frame-level timing, both checked every clk against a position model.
module tb_vga_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       p_tick_a, video_on_a, hsync_a, vsync_a, frame_start_a;
    logic [9:0] pixel_x_a, pixel_y_a;
    logic       p_tick_b, video_on_b, hsync_b, vsync_b, frame_start_b;
    logic [9:0] pixel_x_b, pixel_y_b;

    always #5 clk = ~clk;

    vga_sync dut_a (
        .clk(clk), .rst(rst), .p_tick(p_tick_a), .pixel_x(pixel_x_a), .pixel_y(pixel_y_a),
        .video_on(video_on_a), .hsync(hsync_a), .vsync(vsync_a), .frame_start(frame_start_a)
    );

    // Small timing: H 20/4/6/5 (total 35), V 12/2/2/3 (total 19), 3 clks per pixel.
    vga_sync #(
        .H_DISPLAY(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
        .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CLK_DIV(3)
    ) dut_b (
        .clk(clk), .rst(rst), .p_tick(p_tick_b), .pixel_x(pixel_x_b), .pixel_y(pixel_y_b),
        .video_on(video_on_b), .hsync(hsync_b), .vsync(vsync_b), .frame_start(frame_start_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic p;
        int   x;
        int   y;
        logic von;
        logic hs;
        logic vs;
        logic fs;
    } exp_t;

    // n = clk edges since the last reset edge. Each pixel position lasts
    // d clks; the first p_tick appears d clks after release and the counters
    // advance on the edge after each p_tick.
    function automatic exp_t model(input longint n, input int hd, input int hf, input int hs,
                                   input int hb, input int vd, input int vf, input int vs,
                                   input int vb, input int d);
        exp_t   e;
        longint t, pos;
        int     ht, vt;
        ht    = hd + hf + hs + hb;
        vt    = vd + vf + vs + vb;
        t     = (n == 0) ? 0 : (n - 1) / d;
        pos   = t % (ht * vt);
        e.x   = int'(pos % ht);
        e.y   = int'(pos / ht);
        e.p   = (n > 0) && (n % d == 0);
        e.hs  = !((e.x >= hd + hf) && (e.x < hd + hf + hs));
        e.vs  = !((e.y >= vd + vf) && (e.y < vd + vf + vs));
        e.von = (n >= 1) && (e.x < hd) && (e.y < vd);
        e.fs  = (n >= d + 1) && ((n - 1) % d == 0) && (pos == 0);
        return e;
    endfunction

    longint n_edges  = 0;
    logic   model_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            n_edges  <= 0;
            model_on <= 1'b1;
        end else begin
            n_edges <= n_edges + 1;
        end
    end

    always @(negedge clk) begin
        exp_t ea, eb;
        if (model_on) begin
            ea = model(n_edges, 640, 16, 96, 48, 480, 10, 2, 33, 4);
            eb = model(n_edges, 20, 4, 6, 5, 12, 2, 2, 3, 3);
            chk("a_p_tick", p_tick_a, ea.p);
            chk("a_pixel_x", pixel_x_a, ea.x);
            chk("a_pixel_y", pixel_y_a, ea.y);
            chk("a_video_on", video_on_a, ea.von);
            chk("a_hsync", hsync_a, ea.hs);
            chk("a_vsync", vsync_a, ea.vs);
            chk("a_frame_start", frame_start_a, ea.fs);
            chk("b_p_tick", p_tick_b, eb.p);
            chk("b_pixel_x", pixel_x_b, eb.x);
            chk("b_pixel_y", pixel_y_b, eb.y);
            chk("b_video_on", video_on_b, eb.von);
            chk("b_hsync", hsync_b, eb.hs);
            chk("b_vsync", vsync_b, eb.vs);
            chk("b_frame_start", frame_start_b, eb.fs);
        end
    end

    // Event monitors with hand-derived literal expectations (no resets while enabled).
    logic       mon_en = 1'b0;
    logic       mon_first = 1'b1;
    logic       prev_hs_a, prev_von_a, prev_hs_b, prev_vs_b;
    logic [9:0] prev_x_a, prev_y_a;
    int         hs_low_ticks = 0;
    int         line_wraps = 0;
    int         hs_pulses_a = 0;
    int         frames_b = 0;
    longint     clk_since_fs = 0;
    int         hs_falls_b = 0;
    int         von_ticks_b = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!mon_first) begin
                if (prev_hs_a && !hsync_a) begin
                    chk("a_hsync_fall_x", pixel_x_a, 656);
                    hs_low_ticks = 0;
                end
                if (!prev_hs_a && hsync_a) begin
                    chk("a_hsync_rise_x", pixel_x_a, 752);
                    chk("a_hsync_low_ticks", hs_low_ticks, 96);
                    hs_pulses_a++;
                end
                if (prev_x_a == 10'd799 && pixel_x_a == 10'd0) begin
                    chk("a_line_wrap_y", pixel_y_a, prev_y_a + 10'd1);
                    line_wraps++;
                end
                if (prev_von_a && !video_on_a) chk("a_video_off_x", pixel_x_a, 640);
                if (!prev_von_a && video_on_a) chk("a_video_on_x", pixel_x_a, 0);
                if (prev_vs_b && !vsync_b) begin
                    chk("b_vsync_fall_y", pixel_y_b, 14);
                    chk("b_vsync_fall_x", pixel_x_b, 0);
                end
                if (!prev_vs_b && vsync_b) chk("b_vsync_rise_y", pixel_y_b, 16);
                if (prev_hs_b && !hsync_b) hs_falls_b++;
            end
            if (p_tick_a && !hsync_a) hs_low_ticks++;
            if (p_tick_b && video_on_b) von_ticks_b++;
            clk_since_fs++;
            if (frame_start_b) begin
                chk("b_fs_pixel", {pixel_y_b, pixel_x_b}, 0);
                if (frames_b > 0) begin
                    chk("b_frame_clks", clk_since_fs, 35 * 19 * 3);
                    chk("b_hsync_falls_per_frame", hs_falls_b, 19);
                    chk("b_video_ticks_per_frame", von_ticks_b, 20 * 12);
                end
                frames_b++;
                clk_since_fs = 0;
                hs_falls_b   = 0;
                von_ticks_b  = 0;
            end
            prev_hs_a  = hsync_a;
            prev_von_a = video_on_a;
            prev_x_a   = pixel_x_a;
            prev_y_a   = pixel_y_a;
            prev_hs_b  = hsync_b;
            prev_vs_b  = vsync_b;
            mon_first  = 1'b0;
        end
    end

    initial begin
        int wait_clks;
        int gap;
        int len;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pixel_x", pixel_x_a, 0);
        chk("rst_hsync", hsync_a, 1);
        chk("rst_vsync", vsync_a, 1);
        chk("rst_video_on", video_on_a, 0);
        chk("rst_p_tick", p_tick_a, 0);

        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("start_p_tick", p_tick_a, (k % 4 == 0) ? 1 : 0);
            chk("start_pixel_x", pixel_x_a, (k - 1) / 4);
        end

        mon_en = 1'b1;
        repeat (12000) @(negedge clk);
        mon_en = 1'b0;
        chk("a_line_wraps_seen", line_wraps >= 3, 1);
        chk("a_hsync_pulses_seen", hs_pulses_a >= 3, 1);
        chk("b_frames_seen", frames_b >= 5, 1);

        // Reset mid-line at a known position.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_clks = 0;
        while (!(pixel_x_a == 10'd300 && pixel_y_a == 10'd1) && wait_clks < 10000) begin
            @(negedge clk);
            wait_clks++;
        end
        chk("reach_300_1_in_budget", wait_clks < 10000, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_x", pixel_x_a, 0);
        chk("midrst_y", pixel_y_a, 0);
        chk("midrst_hsync", hsync_a, 1);
        chk("midrst_vsync", vsync_a, 1);
        chk("midrst_video_on_release_clk", video_on_a, 0);
        @(negedge clk);
        chk("midrst_video_on_second_clk", video_on_a, 1);

        // Random reset pulses at random positions; the per-clk model covers everything.
        for (int i = 0; i < 20; i++) begin
            gap = $urandom_range(1, 1500);
            len = $urandom_range(1, 3);
            repeat (gap) @(negedge clk);
            rst = 1'b1;
            repeat (len) @(negedge clk);
            rst = 1'b0;
        end
        repeat (200) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
